// File: rtl/wb_traffic_gen.sv
// Wishbone B3 burst traffic generator.
// Each transaction writes one incrementing burst of LFSR data to a random,
// burst-aligned window address. It then reads the same burst back and
// counts data mismatches and bus errors.
module wb_traffic_gen #(
   parameter int              DW           = 32,
   parameter int              AW           = 32,
   parameter longint unsigned MEM_LOW      = 0,
   parameter int unsigned     MEM_SIZE     = 16384,
   parameter int              BURST_LEN    = 8,
   parameter int unsigned     TRANSACTIONS = 1000,
   parameter logic [31:0]     SEED         = 32'h1
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   input  logic            start,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic            wb_we_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic [2:0]      wb_cti_o,
   output logic [1:0]      wb_bte_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   output logic            busy,
   output logic            done,
   output logic [15:0]     err_count,
   output logic [31:0]     trans_count
);

   localparam int          BYTES       = DW / 8;
   localparam int          BURST_BYTES = BURST_LEN * BYTES;
   localparam int          BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int          SHIFT       = $clog2(BYTES);
   localparam logic [31:0] POLY        = 32'h8020_0003;
   localparam logic [31:0] OFF_MASK    = 32'(MEM_SIZE - 1) & ~32'(BURST_BYTES - 1);

   typedef enum logic [2:0] {IDLE, ADDR, WRITE, GAP, READ, NEXT, DONE} state_t;

   state_t            state;
   state_t            next_state;
   logic [31:0]       addr_lfsr;
   logic [31:0]       addr_lfsr_next;
   logic [31:0]       data_lfsr;
   logic [31:0]       burst_seed;
   logic [AW-1:0]     base;
   logic [BEAT_W-1:0] beat;
   logic [63:0]       rep;
   logic [DW-1:0]     exp_word;
   logic              in_burst;
   logic              bus_ack;
   logic              bus_err;
   logic              last_beat;
   logic              mismatch;
   logic              start_ok;
   logic              last_trans;

   // Galois LFSR with taps 32,22,2,1, shifting toward bit 0
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? POLY : 32'h0);
   endfunction

   assign addr_lfsr_next = lfsr_step(addr_lfsr);
   assign rep            = {data_lfsr, data_lfsr};
   assign exp_word       = rep[DW-1:0];
   assign in_burst       = (state == WRITE) || (state == READ);
   assign bus_err        = in_burst && wb_err_i;
   assign bus_ack        = in_burst && wb_ack_i && !wb_err_i;
   assign last_beat      = (beat == BEAT_W'(BURST_LEN - 1));
   assign mismatch       = bus_ack && (state == READ) && (wb_dat_i != exp_word);
   assign start_ok       = start && ((state == IDLE) || (state == DONE));
   assign last_trans     = ((trans_count + 32'd1) == 32'(TRANSACTIONS));

   // State register
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic; an error response always wins over an ack
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE, DONE: if (start) next_state = ADDR;
         ADDR:       next_state = WRITE;
         WRITE: begin
            if (wb_err_i)                    next_state = NEXT;
            else if (wb_ack_i && last_beat)  next_state = GAP;
         end
         GAP:        next_state = READ;
         READ: begin
            if (wb_err_i)                    next_state = NEXT;
            else if (wb_ack_i && last_beat)  next_state = NEXT;
         end
         NEXT:       next_state = last_trans ? DONE : ADDR;
         default:    next_state = IDLE;
      endcase
   end

   // Bus outputs are decoded from state so they hold steady through wait states
   always_comb begin
      wb_adr_o = '0;
      wb_dat_o = '0;
      wb_sel_o = '0;
      wb_we_o  = 1'b0;
      wb_cyc_o = 1'b0;
      wb_stb_o = 1'b0;
      wb_cti_o = 3'b000;
      wb_bte_o = 2'b00;
      busy     = (state != IDLE) && (state != DONE);
      done     = (state == DONE);
      if (in_burst) begin
         wb_cyc_o = 1'b1;
         wb_stb_o = 1'b1;
         wb_sel_o = '1;
         wb_adr_o = base + (AW'(beat) << SHIFT);
         if (BURST_LEN == 1)  wb_cti_o = 3'b000;
         else if (last_beat)  wb_cti_o = 3'b111;
         else                 wb_cti_o = 3'b010;
         if (state == WRITE) begin
            wb_we_o  = 1'b1;
            wb_dat_o = exp_word;
         end
      end
   end

   // Address/data generators and beat counter
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         addr_lfsr  <= SEED;
         data_lfsr  <= SEED;
         burst_seed <= SEED;
         base       <= '0;
         beat       <= '0;
      end else begin
         unique case (state)
            ADDR: begin
               addr_lfsr  <= addr_lfsr_next;
               base       <= AW'(MEM_LOW) + AW'(addr_lfsr_next & OFF_MASK);
               burst_seed <= data_lfsr;
               beat       <= '0;
            end
            WRITE, READ: begin
               if (bus_err) begin
                  beat <= '0;
               end else if (bus_ack) begin
                  beat      <= last_beat ? '0 : beat + BEAT_W'(1);
                  data_lfsr <= lfsr_step(data_lfsr);
               end
            end
            GAP: begin
               data_lfsr <= burst_seed;
               beat      <= '0;
            end
            default: beat <= '0;
         endcase
      end
   end

   // Run statistics: cleared by an accepted start, errors saturate
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         err_count   <= '0;
         trans_count <= '0;
      end else if (start_ok) begin
         err_count   <= '0;
         trans_count <= '0;
      end else begin
         if ((bus_err || mismatch) && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
         if (state == NEXT)
            trans_count <= trans_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Directed testbench for wb_traffic_gen.
// Instance A is 32-bit with 8-beat bursts. Instance B is 64-bit with single beats.
// Each instance has a small memory slave and a beat recorder.
module tb_wb_traffic_gen;

   logic clk;
   logic rst;
   logic start_a;
   logic start_b;
   int   errors;
   int   checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance A: DW=32, BURST_LEN=8, 4 transactions
   logic [31:0] a_adr, a_dat_o, a_dat_i, a_trans;
   logic [3:0]  a_sel;
   logic [2:0]  a_cti;
   logic [1:0]  a_bte;
   logic [15:0] a_errc;
   logic        a_we, a_cyc, a_stb, a_ack, a_err, a_busy, a_done;

   wb_traffic_gen #(.DW(32), .AW(32), .MEM_LOW(64'h1000), .MEM_SIZE(1024),
                    .BURST_LEN(8), .TRANSACTIONS(4), .SEED(32'h0000_0F00)) dut_a (
      .wb_clk(clk), .wb_rst(rst), .start(start_a),
      .wb_adr_o(a_adr), .wb_dat_o(a_dat_o), .wb_sel_o(a_sel), .wb_we_o(a_we),
      .wb_cyc_o(a_cyc), .wb_stb_o(a_stb), .wb_cti_o(a_cti), .wb_bte_o(a_bte),
      .wb_dat_i(a_dat_i), .wb_ack_i(a_ack), .wb_err_i(a_err),
      .busy(a_busy), .done(a_done), .err_count(a_errc), .trans_count(a_trans));

   // ---------------- instance B: DW=64, BURST_LEN=1, 3 transactions
   logic [31:0] b_adr, b_trans;
   logic [63:0] b_dat_o, b_dat_i;
   logic [7:0]  b_sel;
   logic [2:0]  b_cti;
   logic [1:0]  b_bte;
   logic [15:0] b_errc;
   logic        b_we, b_cyc, b_stb, b_ack, b_err, b_busy, b_done;

   wb_traffic_gen #(.DW(64), .AW(32), .MEM_LOW(64'h0), .MEM_SIZE(512),
                    .BURST_LEN(1), .TRANSACTIONS(3), .SEED(32'h0000_0F00)) dut_b (
      .wb_clk(clk), .wb_rst(rst), .start(start_b),
      .wb_adr_o(b_adr), .wb_dat_o(b_dat_o), .wb_sel_o(b_sel), .wb_we_o(b_we),
      .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_cti_o(b_cti), .wb_bte_o(b_bte),
      .wb_dat_i(b_dat_i), .wb_ack_i(b_ack), .wb_err_i(b_err),
      .busy(b_busy), .done(b_done), .err_count(b_errc), .trans_count(b_trans));

   // Hand-derived burst bases for seed 0x0F00: successive LFSR states
   // 0x780, 0x3C0, 0x1E0, 0xF0 masked by the window/burst mask.
   logic [31:0] bases_a [4] = '{32'h1380, 32'h13C0, 32'h11E0, 32'h10E0};
   logic [31:0] bases_b [3] = '{32'h180, 32'h1C0, 32'h1E0};

   // ---------------- slave A configuration (pairs 1-based, beats 0-based; 0 pair = off)
   int a_waits, flip_pair, flip_beat, err_pair, err_beat;

   // ---------------- slave A state
   logic [31:0] mem_a [256];
   int          a_wait_cnt, a_beat_cnt, a_pair, a_cur_pair;
   logic        a_prev_cyc, a_ready, a_err_hit, a_flip;

   // Slave A response logic: optional wait states, error and data-flip injection
   always_comb begin
      a_cur_pair = a_pair + ((a_cyc && a_we && !a_prev_cyc) ? 1 : 0);
      a_ready    = a_cyc && a_stb && (a_wait_cnt >= a_waits);
      a_err_hit  = a_we && (a_cur_pair == err_pair) && (a_beat_cnt == err_beat);
      a_flip     = !a_we && (a_cur_pair == flip_pair) && (a_beat_cnt == flip_beat);
      a_ack      = a_ready && !a_err_hit;
      a_err      = a_ready && a_err_hit;
      a_dat_i    = (a_cyc && a_stb && !a_we) ? (mem_a[a_adr[9:2]] ^ {31'b0, a_flip}) : 32'h0;
   end

   // Slave A registers and memory
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         a_prev_cyc <= 1'b0;
         a_pair     <= 0;
         a_wait_cnt <= 0;
         a_beat_cnt <= 0;
      end else begin
         a_prev_cyc <= a_cyc;
         if (a_cyc && a_we && !a_prev_cyc) a_pair <= a_pair + 1;
         if (!(a_cyc && a_stb)) begin
            a_wait_cnt <= 0;
            a_beat_cnt <= 0;
         end else if (a_ack || a_err) begin
            a_wait_cnt <= 0;
            a_beat_cnt <= a_beat_cnt + 1;
            if (a_ack && a_we) mem_a[a_adr[9:2]] <= a_dat_o;
         end else begin
            a_wait_cnt <= a_wait_cnt + 1;
         end
      end
   end

   // ---------------- recorder A (samples on the falling edge)
   logic [31:0] qa_adr[$], qa_dat[$];
   logic [2:0]  qa_cti[$];
   logic        qa_we[$];
   logic [3:0]  qa_sel[$];
   logic [1:0]  qa_bte[$];
   int          w_bursts, r_bursts, unstable, stalls, late_cyc;
   logic        r_prev_cyc, r_stalled, r_err_prev, h_we;
   logic [31:0] h_adr, h_dat;
   logic [2:0]  h_cti;
   logic [3:0]  h_sel;

   // Record accepted beats, burst starts, stall stability and post-error cyc
   always @(negedge clk) begin
      if (rst) begin
         qa_adr.delete(); qa_dat.delete(); qa_cti.delete();
         qa_we.delete();  qa_sel.delete(); qa_bte.delete();
         w_bursts <= 0; r_bursts <= 0; unstable <= 0; stalls <= 0; late_cyc <= 0;
         r_prev_cyc <= 1'b0; r_stalled <= 1'b0; r_err_prev <= 1'b0;
      end else begin
         if (r_err_prev && a_cyc) late_cyc <= late_cyc + 1;
         if (a_cyc && !r_prev_cyc) begin
            if (a_we) w_bursts <= w_bursts + 1;
            else      r_bursts <= r_bursts + 1;
         end
         if (r_stalled && (!a_cyc || !a_stb || a_adr != h_adr || a_dat_o != h_dat ||
                           a_cti != h_cti || a_we != h_we || a_sel != h_sel))
            unstable <= unstable + 1;
         r_stalled <= a_cyc && a_stb && !a_ack && !a_err;
         if (a_cyc && a_stb && !a_ack && !a_err) stalls <= stalls + 1;
         h_adr <= a_adr; h_dat <= a_dat_o; h_cti <= a_cti; h_we <= a_we; h_sel <= a_sel;
         if (a_cyc && a_stb && (a_ack || a_err)) begin
            qa_adr.push_back(a_adr);
            qa_dat.push_back(a_we ? a_dat_o : a_dat_i);
            qa_cti.push_back(a_cti);
            qa_we.push_back(a_we);
            qa_sel.push_back(a_sel);
            qa_bte.push_back(a_bte);
         end
         r_err_prev <= a_cyc && a_stb && a_err;
         r_prev_cyc <= a_cyc;
      end
   end

   // ---------------- slave B: zero-wait memory, never errors
   logic [63:0] mem_b [64];
   assign b_ack   = b_cyc && b_stb;
   assign b_err   = 1'b0;
   assign b_dat_i = (b_cyc && b_stb && !b_we) ? mem_b[b_adr[8:3]] : 64'h0;

   // Slave B memory write
   always @(posedge clk) begin
      if (b_ack && b_we) mem_b[b_adr[8:3]] <= b_dat_o;
   end

   logic [31:0] qb_adr[$];
   logic [63:0] qb_dat[$];
   logic [2:0]  qb_cti[$];
   logic        qb_we[$];
   logic [7:0]  qb_sel[$];
   logic [1:0]  qb_bte[$];

   // Recorder B: accepted beats on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         qb_adr.delete(); qb_dat.delete(); qb_cti.delete();
         qb_we.delete();  qb_sel.delete(); qb_bte.delete();
      end else if (b_cyc && b_stb && b_ack) begin
         qb_adr.push_back(b_adr);
         qb_dat.push_back(b_we ? b_dat_o : b_dat_i);
         qb_cti.push_back(b_cti);
         qb_we.push_back(b_we);
         qb_sel.push_back(b_sel);
         qb_bte.push_back(b_bte);
      end
   end

   // ---------------- reference data generator (seed 0x0F00, taps 32,22,2,1)
   function automatic logic [31:0] lfsr_n(input int n);
      logic [31:0] v;
      v = 32'h0000_0F00;
      for (int i = 0; i < n; i++) v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
      return v;
   endfunction

   // ---------------- stimulus helpers
   task automatic set_cfg(input int w, input int fp, input int fb, input int ep, input int eb);
      a_waits = w; flip_pair = fp; flip_beat = fb; err_pair = ep; err_beat = eb;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_a();
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
   endtask

   task automatic wait_done_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (a_done) begin ok = 1'b1; return; end
      end
   endtask

   // ---------------- tests
   task automatic test_reset();
      set_cfg(0, 0, 0, 0, 0);
      @(negedge clk); rst = 1'b1;
      #1;
      checks++; if ({a_cyc, a_stb, a_we, a_busy, a_done} !== 5'b0) begin errors++;
         $display("[TB] FAIL reset_ctrl_a: got %b expected 00000", {a_cyc, a_stb, a_we, a_busy, a_done}); end
      checks++; if ({a_adr, a_dat_o, a_sel, a_cti, a_bte} !== 73'b0) begin errors++;
         $display("[TB] FAIL reset_bus_a: got adr=%h dat=%h sel=%h cti=%b bte=%b expected all zero", a_adr, a_dat_o, a_sel, a_cti, a_bte); end
      checks++; if ({a_errc, a_trans} !== 48'b0) begin errors++;
         $display("[TB] FAIL reset_counts_a: got err=%0d trans=%0d expected 0/0", a_errc, a_trans); end
      checks++; if ({b_cyc, b_stb, b_we, b_busy, b_done, b_adr, b_dat_o, b_sel, b_cti, b_bte} !== 114'b0) begin errors++;
         $display("[TB] FAIL reset_all_b: got cyc=%b adr=%h dat=%h sel=%h expected zero", b_cyc, b_adr, b_dat_o, b_sel); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if ({a_cyc, a_busy, a_done} !== 3'b0) begin errors++;
         $display("[TB] FAIL idle_after_reset: got cyc/busy/done=%b expected 000", {a_cyc, a_busy, a_done}); end
   endtask

   task automatic test_basic();
      bit ok;
      int n;
      logic [31:0] e_adr, e_dat;
      logic [2:0]  e_cti;
      logic        e_we;
      set_cfg(0, 0, 0, 0, 0);
      do_reset();
      pulse_a();
      wait_done_a(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_done: done not seen within 4000 cycles, required 1"); end
      checks++; if (a_errc !== 16'd0) begin errors++; $display("[TB] FAIL basic_err_count: got %0d expected 0", a_errc); end
      checks++; if (a_trans !== 32'd4) begin errors++; $display("[TB] FAIL basic_trans_count: got %0d expected 4", a_trans); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 0", a_busy); end
      checks++; if (w_bursts != 4 || r_bursts != 4) begin errors++;
         $display("[TB] FAIL basic_bursts: got w=%0d r=%0d expected 4/4", w_bursts, r_bursts); end
      checks++; if (qa_adr.size() != 64) begin errors++; $display("[TB] FAIL basic_beats: got %0d expected 64", qa_adr.size()); end
      n = (qa_adr.size() < 64) ? qa_adr.size() : 64;
      for (int i = 0; i < n; i++) begin
         e_we  = ((i % 16) < 8);
         e_adr = bases_a[i / 16] + 32'((i % 8) * 4);
         e_cti = ((i % 8) == 7) ? 3'b111 : 3'b010;
         e_dat = lfsr_n((i / 16) * 8 + (i % 8));
         checks++;
         if (qa_adr[i] !== e_adr || qa_cti[i] !== e_cti || qa_we[i] !== e_we ||
             qa_sel[i] !== 4'hF || qa_bte[i] !== 2'b00 || qa_dat[i] !== e_dat) begin
            errors++;
            $display("[TB] FAIL basic_beat%0d: got adr=%h cti=%b we=%b sel=%h bte=%b dat=%h expected adr=%h cti=%b we=%b sel=f bte=00 dat=%h",
                     i, qa_adr[i], qa_cti[i], qa_we[i], qa_sel[i], qa_bte[i], qa_dat[i], e_adr, e_cti, e_we, e_dat);
         end
      end
      if (n == 64) begin
         checks++; if (qa_dat[1] !== 32'h0000_0780 || qa_dat[7] !== 32'h0000_001E) begin errors++;
            $display("[TB] FAIL basic_data_pair1: got %h,%h expected 00000780,0000001e", qa_dat[1], qa_dat[7]); end
         checks++; if (qa_dat[16] !== 32'h0000_000F || qa_dat[17] !== 32'h8020_0004) begin errors++;
            $display("[TB] FAIL basic_data_pair2: got %h,%h expected 0000000f,80200004", qa_dat[16], qa_dat[17]); end
      end
   endtask

   task automatic test_wait_states();
      bit ok;
      set_cfg(3, 0, 0, 0, 0);
      do_reset();
      pulse_a();
      wait_done_a(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL wait_done: done not seen within 4000 cycles, required 1"); end
      checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL wait_stable: got %0d changes during waits expected 0", unstable); end
      checks++; if (stalls != 192) begin errors++; $display("[TB] FAIL wait_stalls: got %0d expected 192", stalls); end
      checks++; if (a_errc !== 16'd0 || a_trans !== 32'd4) begin errors++;
         $display("[TB] FAIL wait_counts: got err=%0d trans=%0d expected 0/4", a_errc, a_trans); end
      checks++; if (qa_adr.size() != 64) begin errors++; $display("[TB] FAIL wait_beats: got %0d expected 64", qa_adr.size()); end
      else begin
         checks++; if (qa_adr[9] !== 32'h1384 || qa_adr[63] !== 32'h10FC) begin errors++;
            $display("[TB] FAIL wait_adr: got %h,%h expected 00001384,000010fc", qa_adr[9], qa_adr[63]); end
      end
   endtask

   task automatic test_read_mismatch();
      bit ok;
      set_cfg(0, 2, 5, 0, 0);
      do_reset();
      pulse_a();
      wait_done_a(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL mismatch_done: done not seen within 4000 cycles, required 1"); end
      checks++; if (a_errc !== 16'd1) begin errors++; $display("[TB] FAIL mismatch_err_count: got %0d expected 1", a_errc); end
      checks++; if (a_trans !== 32'd4) begin errors++; $display("[TB] FAIL mismatch_trans_count: got %0d expected 4", a_trans); end
      checks++; if (qa_adr.size() != 64) begin errors++; $display("[TB] FAIL mismatch_beats: got %0d expected 64", qa_adr.size()); end
      else begin
         checks++; if (qa_dat[29] !== (lfsr_n(13) ^ 32'h1)) begin errors++;
            $display("[TB] FAIL mismatch_flipped_word: got %h expected %h", qa_dat[29], lfsr_n(13) ^ 32'h1); end
      end
   endtask

   task automatic test_bus_error();
      bit ok;
      set_cfg(0, 0, 0, 1, 3);
      do_reset();
      pulse_a();
      wait_done_a(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL buserr_done: done not seen within 4000 cycles, required 1"); end
      checks++; if (a_errc !== 16'd1) begin errors++; $display("[TB] FAIL buserr_err_count: got %0d expected 1", a_errc); end
      checks++; if (a_trans !== 32'd4) begin errors++; $display("[TB] FAIL buserr_trans_count: got %0d expected 4", a_trans); end
      checks++; if (late_cyc != 0) begin errors++; $display("[TB] FAIL buserr_cyc_drop: got %0d cycles with cyc after err expected 0", late_cyc); end
      checks++; if (w_bursts != 4 || r_bursts != 3) begin errors++;
         $display("[TB] FAIL buserr_bursts: got w=%0d r=%0d expected 4/3", w_bursts, r_bursts); end
      checks++; if (qa_adr.size() != 52) begin errors++; $display("[TB] FAIL buserr_beats: got %0d expected 52", qa_adr.size()); end
      else begin
         checks++; if (qa_adr[3] !== 32'h138C || qa_adr[4] !== 32'h13C0 || qa_we[4] !== 1'b1) begin errors++;
            $display("[TB] FAIL buserr_next_pair: got %h,%h we=%b expected 0000138c,000013c0 we=1", qa_adr[3], qa_adr[4], qa_we[4]); end
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      int n;
      set_cfg(0, 0, 0, 0, 0);
      do_reset();
      pulse_a();
      for (int i = 0; i < 200 && qa_adr.size() < 3; i++) @(negedge clk);
      checks++; if (!(a_cyc && a_we)) begin errors++;
         $display("[TB] FAIL midrst_in_burst: got cyc=%b we=%b expected 1/1", a_cyc, a_we); end
      rst = 1'b1;
      #1;
      checks++; if ({a_cyc, a_stb, a_we, a_busy, a_done, a_adr, a_dat_o, a_sel, a_cti, a_bte} !== 78'b0) begin errors++;
         $display("[TB] FAIL midrst_outputs: got cyc=%b adr=%h dat=%h sel=%h cti=%b expected zero", a_cyc, a_adr, a_dat_o, a_sel, a_cti); end
      checks++; if ({a_errc, a_trans} !== 48'b0) begin errors++;
         $display("[TB] FAIL midrst_counts: got err=%0d trans=%0d expected 0/0", a_errc, a_trans); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if ({a_cyc, a_busy} !== 2'b0) begin errors++;
         $display("[TB] FAIL midrst_idle: got cyc/busy=%b expected 00", {a_cyc, a_busy}); end
      pulse_a();
      wait_done_a(ok);
      checks++; if (!ok || a_trans !== 32'd4 || a_errc !== 16'd0) begin errors++;
         $display("[TB] FAIL midrst_rerun: got done=%b trans=%0d err=%0d expected 1/4/0", a_done, a_trans, a_errc); end
      checks++; if (qa_adr.size() != 64) begin errors++; $display("[TB] FAIL midrst_beats: got %0d expected 64", qa_adr.size()); end
      n = (qa_adr.size() < 64) ? qa_adr.size() : 64;
      for (int i = 0; i < n; i += 8) begin
         checks++; if (qa_adr[i] !== bases_a[i / 16]) begin errors++;
            $display("[TB] FAIL midrst_burst_adr%0d: got %h expected %h", i / 8, qa_adr[i], bases_a[i / 16]); end
      end
   endtask

   task automatic test_single_beat();
      bit ok;
      logic [63:0] e_dat;
      do_reset();
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (b_done) ok = 1'b1;
      end
      checks++; if (!ok) begin errors++; $display("[TB] FAIL single_done: done not seen within 500 cycles, required 1"); end
      checks++; if (b_errc !== 16'd0 || b_trans !== 32'd3) begin errors++;
         $display("[TB] FAIL single_counts: got err=%0d trans=%0d expected 0/3", b_errc, b_trans); end
      checks++; if (qb_adr.size() != 6) begin errors++; $display("[TB] FAIL single_beats: got %0d expected 6", qb_adr.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            e_dat = {lfsr_n(i / 2), lfsr_n(i / 2)};
            checks++;
            if (qb_adr[i] !== bases_b[i / 2] || qb_cti[i] !== 3'b000 || qb_sel[i] !== 8'hFF ||
                qb_bte[i] !== 2'b00 || qb_we[i] !== ((i % 2) == 0) || qb_dat[i] !== e_dat) begin
               errors++;
               $display("[TB] FAIL single_beat%0d: got adr=%h cti=%b sel=%h bte=%b we=%b dat=%h expected adr=%h cti=000 sel=ff bte=00 we=%b dat=%h",
                        i, qb_adr[i], qb_cti[i], qb_sel[i], qb_bte[i], qb_we[i], qb_dat[i], bases_b[i / 2], ((i % 2) == 0), e_dat);
            end
         end
         checks++; if (qb_dat[0] !== 64'h0000_0F00_0000_0F00) begin errors++;
            $display("[TB] FAIL single_first_word: got %h expected 00000f0000000f00", qb_dat[0]); end
      end
   endtask

   // Test sequence
   initial begin
      errors = 0; checks = 0;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      test_reset();
      test_basic();
      test_wait_states();
      test_read_mismatch();
      test_bus_error();
      test_reset_mid_burst();
      test_single_beat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_traffic_gen.md
WB_TRAFFIC_GEN -- requirements
Module: wb_traffic_gen

Interface
REQ-001 SHALL have parameter DW, default 32: Wishbone data width; legal values 16, 32, 64.
REQ-002 SHALL have parameter AW, default 32: byte-address width.
REQ-003 SHALL have parameter MEM_LOW, default 0: lowest byte address of the test window.
REQ-004 SHALL have parameter MEM_SIZE, default 16384: window size in bytes; power of two and a multiple of BURST_LEN*DW/8.
REQ-005 SHALL have parameter BURST_LEN, default 8: beats per burst; legal values 1, 4, 8, 16.
REQ-006 SHALL have parameter TRANSACTIONS, default 1000: write/read-back pairs per run.
REQ-007 SHALL have parameter SEED, default 32'h1, which must be nonzero: initial LFSR state.
REQ-008 SHALL have port wb_clk, in, 1: sole clock.
REQ-009 SHALL have port wb_rst, in, 1: asynchronous, active-high reset.
REQ-010 SHALL have port start, in, 1: one-cycle pulse that begins a run.
REQ-011 SHALL have output ports wb_adr_o (AW), wb_dat_o (DW), wb_sel_o (DW/8), wb_we_o (1), wb_cyc_o (1), wb_stb_o (1), wb_cti_o (3), wb_bte_o (2): Wishbone B3 master outputs.
REQ-012 SHALL have input ports wb_dat_i (DW), wb_ack_i (1), wb_err_i (1): slave responses.
REQ-013 SHALL have port busy, out, 1: a run is in progress.
REQ-014 SHALL have port done, out, 1: run complete; sticky.
REQ-015 SHALL have port err_count, out, 16: count of mismatches plus bus errors; saturates at 16'hFFFF.
REQ-016 SHALL have port trans_count, out, 32: completed transaction pairs.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, WRITE, GAP, READ, NEXT, DONE.
REQ-018 IDLE/DONE + start SHALL go to ADDR, clear done, err_count and trans_count, and set busy; start in any other state SHALL be ignored.
REQ-019 ADDR (1 cycle) SHALL advance the 32-bit Galois address LFSR (taps 32,22,2,1), latch base = MEM_LOW + (lfsr & (MEM_SIZE-1) & ~(BURST_LEN*DW/8-1)), latch the data-LFSR state as burst_seed, then enter WRITE.
REQ-020 WRITE SHALL assert cyc/stb/we with sel all-ones, bte=2'b00, and adr = base + beat*DW/8.
REQ-021 cti SHALL be 3'b010 on every beat except the last, which is 3'b111; with BURST_LEN=1, cti SHALL be 3'b000.
REQ-022 Outputs SHALL hold stable until wb_ack_i; the beat counter and data LFSR SHALL advance only on ack; wb_dat_o SHALL come from the data LFSR, low DW bits, with the LFSR replicated when DW=64.
REQ-023 On the last-beat ack, the FSM SHALL go to GAP: cyc/stb low for exactly one cycle; the data LFSR SHALL reload burst_seed; then READ.
REQ-024 READ SHALL use the same addresses/cti/bte as WRITE with we=0; on each ack, wb_dat_i SHALL be compared with the regenerated expected word, a mismatch incrementing err_count.
REQ-025 wb_err_i sampled with cyc&stb SHALL increment err_count, terminate the burst (cyc/stb low next cycle), and go to NEXT, skipping any remaining read phase.
REQ-026 wb_ack_i and wb_err_i both high SHALL be treated as err only.
REQ-027 NEXT (1 cycle) SHALL increment trans_count; if it equals TRANSACTIONS -> DONE (busy=0, done=1), else -> ADDR.
REQ-028 Acks and errs with cyc low SHALL be ignored.
REQ-029 Address arithmetic SHALL wrap modulo 2^AW; bursts SHALL never cross the window because base is burst-aligned.

Reset
REQ-030 Asserting wb_rst at any time, including mid-burst, SHALL immediately force: state IDLE; cyc, stb, we, busy, done = 0; adr, dat, sel, cti, bte = 0; err_count, trans_count = 0; both LFSRs = SEED.
REQ-031 After wb_rst deasserts, the block SHALL idle until start.

Verification
REQ-032 Test: DW=32, BURST_LEN=8, TRANSACTIONS=4, zero-wait memory slave, start -> 4 write bursts and 4 read bursts, each 8 beats; adr steps of 4; cti 010 x7 then 111; done=1, err_count=0, trans_count=4.
REQ-033 Test: slave inserts 3 wait states per beat -> outputs stable during waits; the same final counts as REQ-032.
REQ-034 Test: slave flips bit 0 of read beat 5 in transaction 2 -> err_count=1, run completes with trans_count=4.
REQ-035 Test: wb_err_i on write beat 3 of transaction 1 -> cyc low next cycle, no read burst for that pair, err_count=1, trans_count=4.
REQ-036 Test: BURST_LEN=1, DW=64 -> cti=000, sel=8'hFF, single-beat pairs, err_count=0.
REQ-037 Test: wb_rst mid-write-burst, then start -> all outputs zero during reset, and the rerun's address sequence is identical to a fresh run.
